uart_tx_fifo: RTL and testbench

Parametrised UART transmitter for the Basys 3 serial designs. It accepts bytes over a ready/valid handshake into an internal FIFO and serialises them LSB-first onto `tx_pin`. Data width, parity, stop bits and baud divisor are configurable, and it sends back-to-back frames with no idle gap. It sits between on-board producers (switch/LED logic, command responders) and the FPGA UART TX pin.

---
 rtl/uart_tx_fifo.sv | 190 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO: bytes accepted over ready/valid are
// serialised LSB-first with optional parity and 1 or 2 stop bits, back-to-back.
//
// state    | meaning
// ---------+--------------------------------------------------------
// S_IDLE   | line high, waiting for the FIFO to become non-empty
// S_START  | start bit (low) for CLKS_PER_BIT cycles
// S_DATA   | data bit bit_cnt, LSB first
// S_PARITY | parity bit (only when PARITY != 0)
// S_STOP   | stop bit bit_cnt (high); pops the next byte at the end if any
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 10417,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        s_valid,
   input  logic [DATA_BITS-1:0]        s_data,
   output logic                        s_ready,
   output logic                        tx_pin,
   output logic                        tx_busy,
   output logic                        tx_done,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
   localparam logic [AW:0]      FULL_CNT  = (AW+1)'(FIFO_DEPTH);

   if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
      $error("uart_tx_fifo: DATA_BITS must be 5..8");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
   end

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [AW:0]          count;
   logic                 push, pop, empty, full;
   logic [DATA_BITS-1:0] head;
   logic                 head_par;

   state_t               state, state_next;
   logic [CNT_W-1:0]     baud_cnt, baud_next;
   logic [2:0]           bit_cnt, bit_next;
   logic [DATA_BITS-1:0] shreg, shreg_next;
   logic                 par, par_next;
   logic                 pin_next, done_next, tick;

   assign full       = (count == FULL_CNT);
   assign empty      = (count == '0);
   assign push       = s_valid && !full;
   assign s_ready    = !full;
   assign fifo_count = count;
   assign head       = mem[rd_ptr];
   assign head_par   = (PARITY == 1) ? ~(^head) : (^head);

   // pointers wrap naturally because FIFO_DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= s_data;
   end

   assign tick = (baud_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         par      <= 1'b0;
         tx_pin   <= 1'b1;
         tx_done  <= 1'b0;
      end else begin
         state    <= state_next;
         baud_cnt <= baud_next;
         bit_cnt  <= bit_next;
         shreg    <= shreg_next;
         par      <= par_next;
         tx_pin   <= pin_next;
         tx_done  <= done_next;
      end
   end

   always_comb begin
      state_next = state;
      baud_next  = baud_cnt;
      bit_next   = bit_cnt;
      shreg_next = shreg;
      par_next   = par;
      pop        = 1'b0;
      if (state != S_IDLE) baud_next = tick ? '0 : baud_cnt + 1'b1;
      case (state)
         S_IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               state_next = S_START;
               baud_next  = '0;
               shreg_next = head;
               par_next   = head_par;
            end
         end
         S_START: begin
            if (tick) begin
               state_next = S_DATA;
               bit_next   = '0;
            end
         end
         S_DATA: begin
            if (tick) begin
               if (bit_cnt == DATA_LAST) begin
                  state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                  bit_next   = '0;
               end else begin
                  bit_next   = bit_cnt + 1'b1;
                  shreg_next = shreg >> 1;
               end
            end
         end
         S_PARITY: begin
            if (tick) state_next = S_STOP;
         end
         S_STOP: begin
            if (tick) begin
               if (bit_cnt == STOP_LAST) begin
                  // chain straight into the next start bit when data is waiting
                  if (!empty) begin
                     pop        = 1'b1;
                     state_next = S_START;
                     shreg_next = head;
                     par_next   = head_par;
                  end else begin
                     state_next = S_IDLE;
                  end
               end else begin
                  bit_next = bit_cnt + 1'b1;
               end
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      pin_next = 1'b1;
      case (state_next)
         S_START:  pin_next = 1'b0;
         S_DATA:   pin_next = shreg_next[0];
         S_PARITY: pin_next = par_next;
         default:  pin_next = 1'b1;
      endcase
      done_next = (state == S_STOP) && tick && (bit_cnt == STOP_LAST);
   end

   assign tx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three differently configured instances driven with
// random traffic and compared each cycle against a frame-level line model.
module tb_uart_tx_fifo;
   localparam int NI = 3;
   localparam int CPB [NI] = '{4, 3, 2};
   localparam int DB  [NI] = '{8, 7, 8};
   localparam int PAR [NI] = '{0, 1, 2};
   localparam int SB  [NI] = '{1, 2, 1};
   localparam int DEP [NI] = '{4, 2, 2};

   logic          clk, rst_n;
   logic [NI-1:0] sv;
   logic [7:0]    sd0, sd2;
   logic [6:0]    sd1;
   logic [NI-1:0] s_ready, tx_pin, tx_busy, tx_done;
   logic [2:0]    cnt0;
   logic [1:0]    cnt1, cnt2;

   int n_cmp = 0;
   int n_err = 0;

   int         pos  [NI];
   int         flen [NI];
   logic [11:0] fb  [NI];
   logic       done_e [NI];
   logic [7:0] mq [NI][$];

   uart_tx_fifo #(.CLKS_PER_BIT(CPB[0]), .DATA_BITS(DB[0]), .PARITY(PAR[0]),
                  .STOP_BITS(SB[0]), .FIFO_DEPTH(DEP[0])) u0 (
      .clk(clk), .rst_n(rst_n), .s_valid(sv[0]), .s_data(sd0), .s_ready(s_ready[0]),
      .tx_pin(tx_pin[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]), .fifo_count(cnt0));
   uart_tx_fifo #(.CLKS_PER_BIT(CPB[1]), .DATA_BITS(DB[1]), .PARITY(PAR[1]),
                  .STOP_BITS(SB[1]), .FIFO_DEPTH(DEP[1])) u1 (
      .clk(clk), .rst_n(rst_n), .s_valid(sv[1]), .s_data(sd1), .s_ready(s_ready[1]),
      .tx_pin(tx_pin[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]), .fifo_count(cnt1));
   uart_tx_fifo #(.CLKS_PER_BIT(CPB[2]), .DATA_BITS(DB[2]), .PARITY(PAR[2]),
                  .STOP_BITS(SB[2]), .FIFO_DEPTH(DEP[2])) u2 (
      .clk(clk), .rst_n(rst_n), .s_valid(sv[2]), .s_data(sd2), .s_ready(s_ready[2]),
      .tx_pin(tx_pin[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]), .fifo_count(cnt2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] in_data(input int i);
      case (i)
         0:       return sd0;
         1:       return {1'b0, sd1};
         default: return sd2;
      endcase
   endfunction

   function automatic logic [31:0] dut_count(input int i);
      case (i)
         0:       return {29'd0, cnt0};
         1:       return {30'd0, cnt1};
         default: return {30'd0, cnt2};
      endcase
   endfunction

   // frame = start(0), data LSB first, optional parity, stop(1)s
   task automatic build_frame(input int i, input logic [7:0] b);
      logic p;
      int   n;
      p = 1'b0;
      fb[i] = '1;
      fb[i][0] = 1'b0;
      for (int k = 0; k < DB[i]; k++) begin
         fb[i][1+k] = b[k];
         p = p ^ b[k];
      end
      n = 1 + DB[i];
      if (PAR[i] != 0) begin
         fb[i][n] = (PAR[i] == 1) ? ~p : p;
         n++;
      end
      flen[i] = n + SB[i];
   endtask

   task automatic model_step(input int i);
      int         sz;
      logic       pushed;
      logic [7:0] d;
      sz     = mq[i].size();
      pushed = sv[i] && (sz < DEP[i]);
      d      = in_data(i);
      done_e[i] = 1'b0;
      if (pos[i] >= 0) begin
         if (pos[i] == flen[i] * CPB[i] - 1) begin
            done_e[i] = 1'b1;
            pos[i] = -1;
         end else begin
            pos[i]++;
         end
      end
      if (pos[i] < 0 && mq[i].size() != 0) begin
         build_frame(i, mq[i].pop_front());
         pos[i] = 0;
      end
      if (pushed) mq[i].push_back(d);
   endtask

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         pos[i] = -1;
         done_e[i] = 1'b0;
         mq[i].delete();
      end
   endtask

   task automatic check_all(input string ph);
      logic exp_pin;
      for (int i = 0; i < NI; i++) begin
         exp_pin = (pos[i] < 0) ? 1'b1 : fb[i][pos[i] / CPB[i]];
         chk($sformatf("%s_pin%0d", ph, i), {31'd0, tx_pin[i]}, {31'd0, exp_pin});
         chk($sformatf("%s_busy%0d", ph, i), {31'd0, tx_busy[i]}, {31'd0, pos[i] >= 0});
         chk($sformatf("%s_done%0d", ph, i), {31'd0, tx_done[i]}, {31'd0, done_e[i]});
         chk($sformatf("%s_count%0d", ph, i), dut_count(i), mq[i].size());
         chk($sformatf("%s_ready%0d", ph, i), {31'd0, s_ready[i]},
             {31'd0, mq[i].size() < DEP[i]});
      end
   endtask

   function automatic logic all_idle();
      logic r;
      r = 1'b1;
      for (int i = 0; i < NI; i++)
         if (pos[i] >= 0 || mq[i].size() != 0) r = 1'b0;
      return r;
   endfunction

   task automatic wait_idle(input string tag);
      int t;
      t = 0;
      while (!all_idle() && t < 4000) begin
         @(negedge clk);
         t++;
      end
      if (!all_idle()) chk({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic rand_data();
      sd0 = 8'($urandom);
      sd1 = 7'($urandom);
      sd2 = 8'($urandom);
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else for (int i = 0; i < NI; i++) model_step(i);
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         check_all("cyc");
      end
   end

   initial begin
      int rate;
      int t;
      rst_n = 1'b0;
      sv = '0;
      sd0 = '0;
      sd1 = '0;
      sd2 = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // single directed frames; data changes right after acceptance
      sv = '1;
      sd0 = 8'hA5;
      sd1 = 7'h55;
      sd2 = 8'h07;
      @(negedge clk);
      sv = '0;
      rand_data();
      repeat (60) @(negedge clk);

      // valid held high: FIFOs fill, frames run back-to-back
      sv = '1;
      repeat (40) begin
         rand_data();
         @(negedge clk);
      end
      sv = '0;
      wait_idle("b2b");

      // random traffic at varying load
      for (int blk = 0; blk < 6; blk++) begin
         rate = $urandom_range(5, 95);
         repeat (500) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) sv[i] = ($urandom_range(0, 99) < rate);
            rand_data();
         end
      end
      @(negedge clk);
      sv = '0;
      wait_idle("rnd");

      // reset in the middle of data bit 3 with bytes queued
      sv = '1;
      t = 0;
      while (!(pos[0] >= 0 && pos[0] / CPB[0] == 4) && t < 200) begin
         rand_data();
         @(negedge clk);
         t++;
      end
      if (!(pos[0] >= 0 && pos[0] / CPB[0] == 4)) chk("rst_wait_timeout", 32'd0, 32'd1);
      #2;
      sv = '0;
      rst_n = 1'b0;
      #1;
      check_all("rst");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (120) @(negedge clk);
      wait_idle("end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
